text_console_ctrl: RTL

- Terminal-style write sequencer driving the CPU port of the text VRAM.
- Accepts a byte stream and interprets it: printable ASCII is written with the current colour at the cursor, and control codes move the cursor or clear the screen.
- Scrolls the screen up one row (all four planes) when the cursor passes the last row.
- Sits between a host/UART byte source and the VRAM CPU port, in the cpu_clk domain.

---
 rtl/text_console_ctrl.sv | 266 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/text_console_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : text_console_ctrl
// Brief    : Terminal-style byte interpreter writing characters, colours,
//            scroll and clear sequences into a 4-plane text VRAM CPU port.
// Revision : 1.0
// ============================================================================
module text_console_ctrl #(
    parameter int COLS           = 80,
    parameter int ROWS           = 60,
    parameter int ADDR_WIDTH     = $clog2(COLS*ROWS*4),
    parameter int COL_W          = $clog2(COLS),
    parameter int ROW_W          = $clog2(ROWS),
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                  cpu_clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [7:0]            cmd_data,
    input  logic [7:0]            fg_r,
    input  logic [7:0]            fg_g,
    input  logic [7:0]            fg_b,
    output logic                  vram_we,
    output logic [ADDR_WIDTH-1:0] vram_addr,
    output logic [7:0]            vram_wdata,
    input  logic [7:0]            vram_rdata,
    output logic [COL_W-1:0]      cursor_col,
    output logic [ROW_W-1:0]      cursor_row,
    output logic                  busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_PUT    = 2'd1,
        S_SCROLL = 2'd2,
        S_CLEAR  = 2'd3
    } state_t;

    localparam state_t                c_RESET_STATE = CLEAR_ON_RESET ? S_CLEAR : S_IDLE;
    localparam logic [ADDR_WIDTH-1:0] c_N           = ADDR_WIDTH'(COLS*ROWS);
    localparam logic [ADDR_WIDTH-1:0] c_N_M1        = ADDR_WIDTH'(COLS*ROWS-1);
    localparam logic [ADDR_WIDTH-1:0] c_COLS_A      = ADDR_WIDTH'(COLS);
    localparam logic [ADDR_WIDTH-1:0] c_COPY_LAST   = ADDR_WIDTH'(COLS*(ROWS-1)-1);
    localparam logic [ADDR_WIDTH-1:0] c_LROW_BASE   = ADDR_WIDTH'(COLS*(ROWS-1));
    localparam logic [ADDR_WIDTH-1:0] c_FILL_LAST   = ADDR_WIDTH'(COLS-1);
    localparam logic [ADDR_WIDTH-1:0] c_LAST_ADDR   = ADDR_WIDTH'(4*COLS*ROWS-1);
    localparam logic [ADDR_WIDTH-1:0] c_ONE_A       = ADDR_WIDTH'(1);
    localparam logic [COL_W-1:0]      c_LAST_COL    = COL_W'(COLS-1);
    localparam logic [COL_W-1:0]      c_ONE_C       = COL_W'(1);
    localparam logic [ROW_W-1:0]      c_LAST_ROW    = ROW_W'(ROWS-1);
    localparam logic [ROW_W-1:0]      c_ONE_R       = ROW_W'(1);

    state_t                r_state;
    logic                  r_busy;
    logic                  r_we;
    logic                  r_pass;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [7:0]            r_wdata;
    logic [COL_W-1:0]      r_col;
    logic [ROW_W-1:0]      r_row;
    logic [7:0]            r_fg_r;
    logic [7:0]            r_fg_g;
    logic [7:0]            r_fg_b;
    logic [1:0]            r_plane;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [ADDR_WIDTH-1:0] r_idx;
    logic                  r_rd;
    logic                  r_fill;
    logic [ADDR_WIDTH-1:0] w_idx;

    assign w_idx = ADDR_WIDTH'(r_row) * c_COLS_A + ADDR_WIDTH'(r_col);

    always_ff @(posedge cpu_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_RESET_STATE;
            r_busy  <= CLEAR_ON_RESET;
            r_we    <= 1'b0;
            r_pass  <= 1'b0;
            r_addr  <= '0;
            r_wdata <= 8'h00;
            r_col   <= '0;
            r_row   <= '0;
            r_fg_r  <= 8'h00;
            r_fg_g  <= 8'h00;
            r_fg_b  <= 8'h00;
            r_plane <= 2'd0;
            r_base  <= '0;
            r_idx   <= '0;
            r_rd    <= 1'b0;
            r_fill  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_we   <= 1'b0;
                    r_pass <= 1'b0;
                    if (cmd_valid) begin
                        r_fg_r <= fg_r;
                        r_fg_g <= fg_g;
                        r_fg_b <= fg_b;
                        if (cmd_data >= 8'h20 && cmd_data <= 8'h7E) begin
                            r_state <= S_PUT;
                            r_busy  <= 1'b1;
                            r_we    <= 1'b1;
                            r_addr  <= w_idx;
                            r_wdata <= cmd_data;
                            r_plane <= 2'd0;
                        end else begin
                            case (cmd_data)
                                8'h0A: begin
                                    r_col <= '0;
                                    if (r_row != c_LAST_ROW) begin
                                        r_row <= r_row + c_ONE_R;
                                    end else begin
                                        r_state <= S_SCROLL;
                                        r_busy  <= 1'b1;
                                        r_plane <= 2'd0;
                                        r_base  <= '0;
                                        r_idx   <= '0;
                                        r_rd    <= 1'b1;
                                        r_fill  <= 1'b0;
                                        r_addr  <= c_COLS_A;
                                    end
                                end
                                8'h0D: r_col <= '0;
                                8'h08: begin
                                    if (r_col != '0) r_col <= r_col - c_ONE_C;
                                end
                                8'h0C: begin
                                    r_col   <= '0;
                                    r_row   <= '0;
                                    r_state <= S_CLEAR;
                                    r_busy  <= 1'b1;
                                    r_we    <= 1'b1;
                                    r_addr  <= '0;
                                    r_wdata <= 8'h20;
                                end
                                default: ;
                            endcase
                        end
                    end
                end

                // r_plane is the plane currently on the bus; colours follow the character.
                S_PUT: begin
                    if (r_plane != 2'd3) begin
                        r_plane <= r_plane + 2'd1;
                        r_addr  <= r_addr + c_N;
                        case (r_plane)
                            2'd0:    r_wdata <= r_fg_r;
                            2'd1:    r_wdata <= r_fg_g;
                            default: r_wdata <= r_fg_b;
                        endcase
                    end else begin
                        r_we <= 1'b0;
                        if (r_col != c_LAST_COL) begin
                            r_col   <= r_col + c_ONE_C;
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_col <= '0;
                            if (r_row != c_LAST_ROW) begin
                                r_row   <= r_row + c_ONE_R;
                                r_state <= S_IDLE;
                                r_busy  <= 1'b0;
                            end else begin
                                r_state <= S_SCROLL;
                                r_plane <= 2'd0;
                                r_base  <= '0;
                                r_idx   <= '0;
                                r_rd    <= 1'b1;
                                r_fill  <= 1'b0;
                                r_addr  <= c_COLS_A;
                            end
                        end
                    end
                end

                // Copy words alternate read/write; the write cycle forwards vram_rdata.
                S_SCROLL: begin
                    if (!r_fill) begin
                        if (r_rd) begin
                            r_rd   <= 1'b0;
                            r_we   <= 1'b1;
                            r_pass <= 1'b1;
                            r_addr <= r_base + r_idx;
                        end else begin
                            r_pass <= 1'b0;
                            r_we   <= 1'b0;
                            r_rd   <= 1'b1;
                            if (r_idx == c_COPY_LAST) begin
                                r_idx <= '0;
                                if (r_plane == 2'd3) begin
                                    r_fill  <= 1'b1;
                                    r_rd    <= 1'b0;
                                    r_plane <= 2'd0;
                                    r_base  <= '0;
                                    r_we    <= 1'b1;
                                    r_addr  <= c_LROW_BASE;
                                    r_wdata <= 8'h20;
                                end else begin
                                    r_plane <= r_plane + 2'd1;
                                    r_base  <= r_base + c_N;
                                    r_addr  <= r_base + c_N + c_COLS_A;
                                end
                            end else begin
                                r_idx  <= r_idx + c_ONE_A;
                                r_addr <= r_base + r_idx + c_COLS_A + c_ONE_A;
                            end
                        end
                    end else begin
                        if (r_idx == c_FILL_LAST) begin
                            r_idx <= '0;
                            if (r_plane == 2'd3) begin
                                r_we    <= 1'b0;
                                r_fill  <= 1'b0;
                                r_state <= S_IDLE;
                                r_busy  <= 1'b0;
                            end else begin
                                r_plane <= r_plane + 2'd1;
                                r_base  <= r_base + c_N;
                                r_addr  <= r_base + c_N + c_LROW_BASE;
                                r_wdata <= 8'h00;
                            end
                        end else begin
                            r_idx  <= r_idx + c_ONE_A;
                            r_addr <= r_base + c_LROW_BASE + r_idx + c_ONE_A;
                        end
                    end
                end

                // Entry from reset arrives with we low, so the first edge launches address 0.
                S_CLEAR: begin
                    if (!r_we) begin
                        r_we    <= 1'b1;
                        r_addr  <= '0;
                        r_wdata <= 8'h20;
                    end else if (r_addr == c_LAST_ADDR) begin
                        r_we    <= 1'b0;
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_addr  <= r_addr + c_ONE_A;
                        r_wdata <= (r_addr < c_N_M1) ? 8'h20 : 8'h00;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_we    <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready  = (r_state == S_IDLE);
    assign vram_we    = r_we;
    assign vram_addr  = r_addr;
    assign vram_wdata = r_pass ? vram_rdata : r_wdata;
    assign cursor_col = r_col;
    assign cursor_row = r_row;
    assign busy       = r_busy;

endmodule
`default_nettype wire
